// File: rtl/rv32_enc_pkg.sv
// rv32_enc_pkg: op ids, RV32I opcode/funct constants
// and field-packing helpers shared with decode.
package rv32_enc_pkg;

  localparam logic [5:0] ENC_OP_LUI    = 6'd0;
  localparam logic [5:0] ENC_OP_AUIPC  = 6'd1;
  localparam logic [5:0] ENC_OP_JAL    = 6'd2;
  localparam logic [5:0] ENC_OP_JALR   = 6'd3;
  localparam logic [5:0] ENC_OP_BEQ    = 6'd4;
  localparam logic [5:0] ENC_OP_BNE    = 6'd5;
  localparam logic [5:0] ENC_OP_BLT    = 6'd6;
  localparam logic [5:0] ENC_OP_BGE    = 6'd7;
  localparam logic [5:0] ENC_OP_BLTU   = 6'd8;
  localparam logic [5:0] ENC_OP_BGEU   = 6'd9;
  localparam logic [5:0] ENC_OP_LB     = 6'd10;
  localparam logic [5:0] ENC_OP_LH     = 6'd11;
  localparam logic [5:0] ENC_OP_LW     = 6'd12;
  localparam logic [5:0] ENC_OP_LBU    = 6'd13;
  localparam logic [5:0] ENC_OP_LHU    = 6'd14;
  localparam logic [5:0] ENC_OP_SB     = 6'd15;
  localparam logic [5:0] ENC_OP_SH     = 6'd16;
  localparam logic [5:0] ENC_OP_SW     = 6'd17;
  localparam logic [5:0] ENC_OP_ADDI   = 6'd18;
  localparam logic [5:0] ENC_OP_SLTI   = 6'd19;
  localparam logic [5:0] ENC_OP_SLTIU  = 6'd20;
  localparam logic [5:0] ENC_OP_XORI   = 6'd21;
  localparam logic [5:0] ENC_OP_ORI    = 6'd22;
  localparam logic [5:0] ENC_OP_ANDI   = 6'd23;
  localparam logic [5:0] ENC_OP_SLLI   = 6'd24;
  localparam logic [5:0] ENC_OP_SRLI   = 6'd25;
  localparam logic [5:0] ENC_OP_SRAI   = 6'd26;
  localparam logic [5:0] ENC_OP_ADD    = 6'd27;
  localparam logic [5:0] ENC_OP_SUB    = 6'd28;
  localparam logic [5:0] ENC_OP_SLL    = 6'd29;
  localparam logic [5:0] ENC_OP_SLT    = 6'd30;
  localparam logic [5:0] ENC_OP_SLTU   = 6'd31;
  localparam logic [5:0] ENC_OP_XOR    = 6'd32;
  localparam logic [5:0] ENC_OP_SRL    = 6'd33;
  localparam logic [5:0] ENC_OP_SRA    = 6'd34;
  localparam logic [5:0] ENC_OP_OR     = 6'd35;
  localparam logic [5:0] ENC_OP_AND    = 6'd36;
  localparam logic [5:0] ENC_OP_ECALL  = 6'd37;
  localparam logic [5:0] ENC_OP_EBREAK = 6'd38;
  localparam logic [5:0] ENC_OP_FENCE  = 6'd39;
  localparam logic [5:0] ENC_OP_LI     = 6'd40;

  localparam logic [4:0] OP_MAP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MAP_MISC   = 5'b00011;
  localparam logic [4:0] OP_MAP_OP_IMM = 5'b00100;
  localparam logic [4:0] OP_MAP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_MAP_STORE  = 5'b01000;
  localparam logic [4:0] OP_MAP_OP     = 5'b01100;
  localparam logic [4:0] OP_MAP_LUI    = 5'b01101;
  localparam logic [4:0] OP_MAP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_MAP_JALR   = 5'b11001;
  localparam logic [4:0] OP_MAP_JAL    = 5'b11011;
  localparam logic [4:0] OP_MAP_SYSTEM = 5'b11100;

  localparam logic [6:0] OPC_LOAD   = {OP_MAP_LOAD, 2'b11};
  localparam logic [6:0] OPC_MISC   = {OP_MAP_MISC, 2'b11};
  localparam logic [6:0] OPC_OP_IMM = {OP_MAP_OP_IMM, 2'b11};
  localparam logic [6:0] OPC_AUIPC  = {OP_MAP_AUIPC, 2'b11};
  localparam logic [6:0] OPC_STORE  = {OP_MAP_STORE, 2'b11};
  localparam logic [6:0] OPC_OP     = {OP_MAP_OP, 2'b11};
  localparam logic [6:0] OPC_LUI    = {OP_MAP_LUI, 2'b11};
  localparam logic [6:0] OPC_BRANCH = {OP_MAP_BRANCH, 2'b11};
  localparam logic [6:0] OPC_JALR   = {OP_MAP_JALR, 2'b11};
  localparam logic [6:0] OPC_JAL    = {OP_MAP_JAL, 2'b11};
  localparam logic [6:0] OPC_SYSTEM = {OP_MAP_SYSTEM, 2'b11};

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSN_FENCE  = 32'h0FF0000F;
  localparam logic [31:0] INSN_ECALL  = {25'd0, OPC_SYSTEM};
  localparam logic [31:0] INSN_EBREAK = 32'h00100073;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B,
    FMT_U, FMT_J, FMT_FIX, FMT_BAD
  } enc_fmt_e;

  typedef enum logic {
    ST_IDLE, ST_LI2
  } enc_state_e;

  // True when v is sign-representable in w bits.
  function automatic logic fits_s(
    logic [31:0] v, int unsigned w);
    logic [31:0] t;
    t = 32'($signed(v) >>> (w - 1));
    return (t == '0) || (t == '1);
  endfunction

  function automatic logic [31:0] pack_r(
    logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_i(
    logic [11:0] imm, logic [4:0] rs1,
    logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_s(
    logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3, logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] pack_b(
    logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
    logic [2:0] f3, logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] pack_u(
    logic [19:0] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] pack_j(
    logic [20:1] imm, logic [4:0] rd, logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, opc};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request (op/fields) and response
// (instr/last/err) valid/ready bundle.
interface instr_encoder_if;
  logic        i_valid;
  logic        o_ready;
  logic [5:0]  i_op;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_last;
  logic        o_err;

  modport master (
    output i_valid, i_op, i_rd, i_rs1, i_rs2, i_imm,
    output i_ready,
    input  o_ready, o_valid, o_instr, o_last, o_err
  );

  modport slave (
    input  i_valid, i_op, i_rd, i_rs1, i_rs2, i_imm,
    input  i_ready,
    output o_ready, o_valid, o_instr, o_last, o_err
  );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational op + fields -> {instr, err}.
// Ports: op/rd/rs1/rs2/imm in, instr/err out.
module instr_pack
  import rv32_enc_pkg::*;
#(
  parameter bit EXPAND_LI    = 1'b1,
  parameter bit ERR_ON_RANGE = 1'b1
) (
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  enc_fmt_e    fmt;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [6:0]  opc;
  logic [4:0]  src1;
  logic [31:0] fix;

  always_comb begin
    fmt  = FMT_BAD;
    f3   = F3_ADD;
    f7   = F7_BASE;
    opc  = OPC_OP_IMM;
    src1 = rs1;
    fix  = INSN_EBREAK;
    unique case (op)
      ENC_OP_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
      ENC_OP_AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
      ENC_OP_JAL:   fmt = FMT_J;
      ENC_OP_JALR:  begin fmt = FMT_I; opc = OPC_JALR; end
      ENC_OP_BEQ:   begin fmt = FMT_B; f3 = F3_BEQ; end
      ENC_OP_BNE:   begin fmt = FMT_B; f3 = F3_BNE; end
      ENC_OP_BLT:   begin fmt = FMT_B; f3 = F3_BLT; end
      ENC_OP_BGE:   begin fmt = FMT_B; f3 = F3_BGE; end
      ENC_OP_BLTU:  begin fmt = FMT_B; f3 = F3_BLTU; end
      ENC_OP_BGEU:  begin fmt = FMT_B; f3 = F3_BGEU; end
      ENC_OP_LB:  begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_B; end
      ENC_OP_LH:  begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_H; end
      ENC_OP_LW:  begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_W; end
      ENC_OP_LBU: begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BU; end
      ENC_OP_LHU: begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HU; end
      ENC_OP_SB:    begin fmt = FMT_S; f3 = F3_B; end
      ENC_OP_SH:    begin fmt = FMT_S; f3 = F3_H; end
      ENC_OP_SW:    begin fmt = FMT_S; f3 = F3_W; end
      ENC_OP_ADDI:  begin fmt = FMT_I; f3 = F3_ADD; end
      ENC_OP_SLTI:  begin fmt = FMT_I; f3 = F3_SLT; end
      ENC_OP_SLTIU: begin fmt = FMT_I; f3 = F3_SLTU; end
      ENC_OP_XORI:  begin fmt = FMT_I; f3 = F3_XOR; end
      ENC_OP_ORI:   begin fmt = FMT_I; f3 = F3_OR; end
      ENC_OP_ANDI:  begin fmt = FMT_I; f3 = F3_AND; end
      ENC_OP_SLLI:  begin fmt = FMT_SH; f3 = F3_SLL; end
      ENC_OP_SRLI:  begin fmt = FMT_SH; f3 = F3_SR; end
      ENC_OP_SRAI:  begin fmt = FMT_SH; f3 = F3_SR; f7 = F7_ALT; end
      ENC_OP_ADD:   begin fmt = FMT_R; f3 = F3_ADD; end
      ENC_OP_SUB:   begin fmt = FMT_R; f3 = F3_ADD; f7 = F7_ALT; end
      ENC_OP_SLL:   begin fmt = FMT_R; f3 = F3_SLL; end
      ENC_OP_SLT:   begin fmt = FMT_R; f3 = F3_SLT; end
      ENC_OP_SLTU:  begin fmt = FMT_R; f3 = F3_SLTU; end
      ENC_OP_XOR:   begin fmt = FMT_R; f3 = F3_XOR; end
      ENC_OP_SRL:   begin fmt = FMT_R; f3 = F3_SR; end
      ENC_OP_SRA:   begin fmt = FMT_R; f3 = F3_SR; f7 = F7_ALT; end
      ENC_OP_OR:    begin fmt = FMT_R; f3 = F3_OR; end
      ENC_OP_AND:   begin fmt = FMT_R; f3 = F3_AND; end
      ENC_OP_ECALL:  begin fmt = FMT_FIX; fix = INSN_ECALL; end
      ENC_OP_EBREAK: begin fmt = FMT_FIX; fix = INSN_EBREAK; end
      ENC_OP_FENCE:  begin fmt = FMT_FIX; fix = INSN_FENCE; end
      // Short LI only; the long form is built by the FSM.
      ENC_OP_LI: if (EXPAND_LI) begin
        fmt  = FMT_I;
        src1 = 5'd0;
      end
      default: fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    instr = INSN_EBREAK;
    err   = 1'b1;
    unique case (fmt)
      FMT_R: begin
        instr = pack_r(f7, rs2, rs1, f3, rd, OPC_OP);
        err   = 1'b0;
      end
      FMT_I: begin
        instr = pack_i(imm[11:0], src1, f3, rd, opc);
        err   = ERR_ON_RANGE && !fits_s(imm, 12);
      end
      FMT_SH: begin
        instr = pack_r(f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM);
        err   = ERR_ON_RANGE && (|imm[31:5]);
      end
      FMT_S: begin
        instr = pack_s(imm[11:0], rs2, rs1, f3, OPC_STORE);
        err   = ERR_ON_RANGE && !fits_s(imm, 12);
      end
      FMT_B: begin
        instr = pack_b(imm[12:1], rs2, rs1, f3, OPC_BRANCH);
        err   = imm[0] || (ERR_ON_RANGE && !fits_s(imm, 13));
      end
      FMT_U: begin
        instr = pack_u(imm[31:12], rd, opc);
        err   = 1'b0;
      end
      FMT_J: begin
        instr = pack_j(imm[20:1], rd, OPC_JAL);
        err   = imm[0] || (ERR_ON_RANGE && !fits_s(imm, 21));
      end
      FMT_FIX: begin
        instr = fix;
        err   = 1'b0;
      end
      default: begin
        instr = INSN_EBREAK;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: op requests -> RV32I words, LI expansion FSM.
// Ports: i_clk, i_rst (sync, high), bus (slave handshake).
module instr_encoder
  import rv32_enc_pkg::*;
#(
  parameter bit EXPAND_LI    = 1'b1,
  parameter bit ERR_ON_RANGE = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  instr_encoder_if.slave  bus
);

  enc_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo_q, lo_d;
  logic [31:0] pk_instr;
  logic        pk_err;
  logic [19:0] lui_imm;
  logic        accept, big_li, li2_go;

  instr_pack #(
    .EXPAND_LI    (EXPAND_LI),
    .ERR_ON_RANGE (ERR_ON_RANGE)
  ) u_pack (
    .op    (bus.i_op),
    .rd    (bus.i_rd),
    .rs1   (bus.i_rs1),
    .rs2   (bus.i_rs2),
    .imm   (bus.i_imm),
    .instr (pk_instr),
    .err   (pk_err)
  );

  assign bus.o_ready = (state_q == ST_IDLE)
                    && (!valid_q || bus.i_ready);
  assign accept  = bus.i_valid && bus.o_ready;
  assign big_li  = EXPAND_LI && (bus.i_op == ENC_OP_LI)
                && !fits_s(bus.i_imm, 12);
  assign li2_go  = (state_q == ST_LI2) && bus.i_ready;
  // (imm + 0x800) >> 12: rounds so the signed ADDI low part lands.
  assign lui_imm = bus.i_imm[31:12] + {19'd0, bus.i_imm[11]};

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && big_li) state_d = ST_LI2;
      ST_LI2:  if (bus.i_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q && !bus.i_ready;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    rd_d    = rd_q;
    lo_d    = lo_q;
    unique case (1'b1)
      accept: begin
        valid_d = 1'b1;
        if (big_li) begin
          instr_d = pack_u(lui_imm, bus.i_rd, OPC_LUI);
          last_d  = 1'b0;
          err_d   = 1'b0;
          rd_d    = bus.i_rd;
          lo_d    = bus.i_imm[11:0];
        end else begin
          instr_d = pk_instr;
          last_d  = 1'b1;
          err_d   = pk_err;
        end
      end
      li2_go: begin
        valid_d = 1'b1;
        instr_d = pack_i(lo_q, rd_q, F3_ADD, rd_q, OPC_OP_IMM);
        last_d  = 1'b1;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      lo_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_instr = instr_q;
  assign bus.o_last  = last_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: vector table + scoreboard bench
// for instr_encoder.
module tb_instr_encoder;
  import rv32_enc_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] x_instr;
    logic        x_last;
    logic        x_err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_tot = 0;
  exp_t sb[$];
  vec_t vt[20];

  instr_encoder_if bus();

  instr_encoder #(
    .EXPAND_LI    (1'b1),
    .ERR_ON_RANGE (1'b1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endtask

  task automatic push(logic [31:0] w, logic l, logic e);
    exp_t x;
    x.instr = w;
    x.last  = l;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic drive(logic [5:0] op, logic [4:0] rd,
                       logic [4:0] rs1, logic [4:0] rs2,
                       logic [31:0] imm);
    bus.i_op    = op;
    bus.i_rd    = rd;
    bus.i_rs1   = rs1;
    bus.i_rs2   = rs2;
    bus.i_imm   = imm;
    bus.i_valid = 1'b1;
  endtask

  task automatic send(logic [5:0] op, logic [4:0] rd,
                      logic [4:0] rs1, logic [4:0] rs2,
                      logic [31:0] imm);
    int n = 0;
    drive(op, rd, rs1, rs2, imm);
    @(negedge clk);
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      n_tot++;
      $display("FAIL accept timeout: o_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain pending", sb.size(), 0);
  endtask

  // Scoreboard: a word transfers at the next edge when
  // o_valid && i_ready holds at the falling edge.
  always @(negedge clk) begin
    if (bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL spurious word: got %h want none",
                 bus.o_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr", bus.o_instr, e.instr);
        chk("last", 32'(bus.o_last), 32'(e.last));
        chk("err", 32'(bus.o_err), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_op    = '0;
    bus.i_rd    = '0;
    bus.i_rs1   = '0;
    bus.i_rs2   = '0;
    bus.i_imm   = '0;

    vt[0]  = '{ENC_OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,
               32'h00500093, 1'b1, 1'b0};
    vt[1]  = '{ENC_OP_SW, 5'd0, 5'd1, 5'd2, 32'd8,
               32'h0020A423, 1'b1, 1'b0};
    vt[2]  = '{ENC_OP_BEQ, 5'd0, 5'd1, 5'd2, -32'sd4,
               32'hFE208EE3, 1'b1, 1'b0};
    vt[3]  = '{ENC_OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3,
               32'h00208163, 1'b1, 1'b1};
    vt[4]  = '{ENC_OP_LI, 5'd3, 5'd0, 5'd0, -32'sd2048,
               32'h80000193, 1'b1, 1'b0};
    vt[5]  = '{6'd63, 5'd1, 5'd2, 5'd3, 32'd0,
               32'h00100073, 1'b1, 1'b1};
    vt[6]  = '{ENC_OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096,
               32'h00000093, 1'b1, 1'b1};
    vt[7]  = '{ENC_OP_LUI, 5'd5, 5'd0, 5'd0, 32'h12345678,
               32'h123452B7, 1'b1, 1'b0};
    vt[8]  = '{ENC_OP_JAL, 5'd1, 5'd0, 5'd0, 32'd8,
               32'h008000EF, 1'b1, 1'b0};
    vt[9]  = '{ENC_OP_JAL, 5'd1, 5'd0, 5'd0, 32'h00100000,
               32'h800000EF, 1'b1, 1'b1};
    vt[10] = '{ENC_OP_SRAI, 5'd2, 5'd3, 5'd0, 32'd7,
               32'h4071D113, 1'b1, 1'b0};
    vt[11] = '{ENC_OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32,
               32'h00009093, 1'b1, 1'b1};
    vt[12] = '{ENC_OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0,
               32'h402081B3, 1'b1, 1'b0};
    vt[13] = '{ENC_OP_FENCE, 5'd0, 5'd0, 5'd0, 32'd0,
               32'h0FF0000F, 1'b1, 1'b0};
    vt[14] = '{ENC_OP_ECALL, 5'd0, 5'd0, 5'd0, 32'd0,
               32'h00000073, 1'b1, 1'b0};
    vt[15] = '{ENC_OP_EBREAK, 5'd0, 5'd0, 5'd0, 32'd0,
               32'h00100073, 1'b1, 1'b0};
    vt[16] = '{ENC_OP_LW, 5'd4, 5'd2, 5'd0, -32'sd4,
               32'hFFC12203, 1'b1, 1'b0};
    vt[17] = '{ENC_OP_BNE, 5'd0, 5'd3, 5'd4, 32'd4094,
               32'h7E419FE3, 1'b1, 1'b0};
    vt[18] = '{ENC_OP_LI, 5'd7, 5'd0, 5'd0, 32'd2047,
               32'h7FF00393, 1'b1, 1'b0};
    vt[19] = '{ENC_OP_ADD, 5'd10, 5'd11, 5'd12, 32'd0,
               32'h00C58533, 1'b1, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst o_valid", 32'(bus.o_valid), 0);
    chk("rst o_instr", bus.o_instr, 0);
    chk("rst o_last", 32'(bus.o_last), 0);
    chk("rst o_err", 32'(bus.o_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst o_ready", 32'(bus.o_ready), 1);

    // table, back to back
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      push(vt[i].x_instr, vt[i].x_last, vt[i].x_err);
      send(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2,
           vt[i].imm);
    end
    drain();

    // two-word LI
    push(32'h123462B7, 1'b0, 1'b0);
    push(32'hFFF28293, 1'b1, 1'b0);
    send(ENC_OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    @(negedge clk);
    chk("li2 o_ready", 32'(bus.o_ready), 0);
    drain();

    // 2048 just misses the short form
    push(32'h00001337, 1'b0, 1'b0);
    push(32'h80030313, 1'b1, 1'b0);
    send(ENC_OP_LI, 5'd6, 5'd0, 5'd0, 32'd2048);
    drain();

    // hold output under backpressure
    bus.i_ready = 1'b0;
    push(32'h00500093, 1'b1, 1'b0);
    send(ENC_OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold o_valid", 32'(bus.o_valid), 1);
      chk("hold o_instr", bus.o_instr, 32'h00500093);
      chk("hold o_last", 32'(bus.o_last), 1);
      chk("hold o_ready", 32'(bus.o_ready), 0);
    end
    @(posedge clk);
    #1;
    push(32'h07F0E113, 1'b1, 1'b0);
    bus.i_ready = 1'b1;
    drive(ENC_OP_ORI, 5'd2, 5'd1, 5'd0, 32'h7F);
    @(negedge clk);
    chk("release o_ready", 32'(bus.o_ready), 1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    drain();

    // reset during expansion drops the ADDI word
    push(32'h123462B7, 1'b0, 1'b0);
    send(ENC_OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst o_valid", 32'(bus.o_valid), 0);
    chk("midrst o_ready", 32'(bus.o_ready), 1);
    repeat (4) @(negedge clk);
    chk("midrst queue", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
